// File: rtl/mux2_pingpong_buf.sv
// -----------------------------------------------------------------------------
// mux2_pingpong_buf
//   Two-entry ping-pong buffer feeding a 2:1 mux stage. Accepted words are
//   written alternately into two holding registers (d0/d1). The select s always
//   points at the oldest unconsumed word, so the mux output is FIFO ordered.
//
// Ports
//   clk        in   1      clock, rising edge
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      upstream word present on in_data
//   in_ready   out  1      buffer can accept a word (count != 2)
//   in_data    in   WIDTH  upstream word
//   d0         out  WIDTH  slot 0 register, feeds mux d0
//   d1         out  WIDTH  slot 1 register, feeds mux d1
//   s          out  1      read pointer, feeds mux select
//   out_valid  out  1      selected slot holds a valid word (count != 0)
//   out_ready  in   1      consumer takes the selected word
// -----------------------------------------------------------------------------
module mux2_pingpong_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic             s,
  output logic             out_valid,
  input  logic             out_ready
);

  // Occupancy states; the encoding equals the word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic             push, pop;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      s_q      <= 1'b0;
      d0_q     <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      s_q      <= s_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
    end
  end

  // Next-state, slot write and handshake decode.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    s_d       = s_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;

    case (state_q)
      EMPTY: begin
        if (push) state_d = ONE;
      end
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL: begin
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase

    // In ONE, wr_ptr is always the slot opposite s, so a simultaneous
    // push/pop never overwrites the word being consumed.
    if (push) begin
      if (wr_ptr_q) d1_d = in_data;
      else          d0_d = in_data;
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) s_d = ~s_q;
  end

  assign d0 = d0_q;
  assign d1 = d1_q;
  assign s  = s_q;

endmodule

// File: tb/tb_mux2_pingpong_buf.sv
// -----------------------------------------------------------------------------
// tb_mux2_pingpong_buf
//   Self-checking bench: an occupancy/slot model plus a queue of expected
//   words. Words are queued when a push is modelled and compared against the
//   mux output (s ? d1 : d0) when a pop is modelled.
// -----------------------------------------------------------------------------
module tb_mux2_pingpong_buf;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  int n_checks;
  int n_errors;

  // Bench model
  logic [WIDTH-1:0] exp_q[$];
  int               m_cnt;
  logic             m_wr;
  logic             m_s;
  logic [WIDTH-1:0] m_d[2];

  mux2_pingpong_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .d0        (d0),
    .d1        (d1),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Downstream 2:1 mux.
  assign y = s ? d1 : d0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt  = 0;
    m_wr   = 1'b0;
    m_s    = 1'b0;
    m_d[0] = '0;
    m_d[1] = '0;
  endtask

  // One clock cycle with the inputs currently driven; checks the pre-edge
  // outputs, updates the model, then advances to 1 time unit past the edge.
  task automatic cycle();
    logic             push_m;
    logic             pop_m;
    logic [WIDTH-1:0] exp_y;
    push_m = in_valid && (m_cnt != 2);
    pop_m  = out_ready && (m_cnt != 0);
    check_eq("in_ready", 32'(in_ready), 32'(m_cnt != 2));
    check_eq("out_valid", 32'(out_valid), 32'(m_cnt != 0));
    check_eq("s", 32'(s), 32'(m_s));
    check_eq("d0", 32'(d0), 32'(m_d[0]));
    check_eq("d1", 32'(d1), 32'(m_d[1]));
    if (pop_m) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(1), 32'(0));
      end else begin
        exp_y = exp_q.pop_front();
        check_eq("y", 32'(y), 32'(exp_y));
      end
      m_s = ~m_s;
    end
    if (push_m) begin
      exp_q.push_back(in_data);
      m_d[m_wr] = in_data;
      m_wr      = ~m_wr;
    end
    m_cnt = m_cnt + int'(push_m) - int'(pop_m);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic reset_mid();
    drive(1'b0, '0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("rst_d0", 32'(d0), 32'(0));
    check_eq("rst_d1", 32'(d1), 32'(0));
    check_eq("rst_s", 32'(s), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    drive(1'b0, '0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_out_valid", 32'(out_valid), 32'(0));
    check_eq("init_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, then a one-cycle pop.
    drive(1'b1, 4'hA, 1'b0); cycle();
    check_eq("single_d0", 32'(d0), 32'hA);
    check_eq("single_s", 32'(s), 32'(0));
    check_eq("single_out_valid", 32'(out_valid), 32'(1));
    drive(1'b0, '0, 1'b1); cycle();
    check_eq("single_pop_s", 32'(s), 32'(1));
    check_eq("single_pop_out_valid", 32'(out_valid), 32'(0));

    // Simultaneous push/pop in ONE: 0xC sits in slot 1 with s = 1.
    drive(1'b1, 4'hC, 1'b0); cycle();
    check_eq("sim_pre_d1", 32'(d1), 32'hC);
    drive(1'b1, 4'hD, 1'b1); cycle();
    check_eq("sim_d0", 32'(d0), 32'hD);
    check_eq("sim_s", 32'(s), 32'(0));
    check_eq("sim_out_valid", 32'(out_valid), 32'(1));
    drive(1'b0, '0, 1'b1); cycle();

    // Fresh start, fill and stall.
    reset_mid();
    drive(1'b1, 4'h3, 1'b0); cycle();
    drive(1'b1, 4'h5, 1'b0); cycle();
    check_eq("fill_d0", 32'(d0), 32'h3);
    check_eq("fill_d1", 32'(d1), 32'h5);
    check_eq("fill_in_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h7, 1'b0); cycle();
      check_eq("stall_d0", 32'(d0), 32'h3);
      check_eq("stall_d1", 32'(d1), 32'h5);
      check_eq("stall_in_ready", 32'(in_ready), 32'(0));
    end

    // Reset while FULL, mid-cycle.
    reset_mid();

    // Drain from FULL holding 0x9 then 0x2.
    drive(1'b1, 4'h9, 1'b0); cycle();
    drive(1'b1, 4'h2, 1'b0); cycle();
    drive(1'b0, '0, 1'b1);
    check_eq("drain_y0", 32'(y), 32'h9);
    cycle();
    check_eq("drain_in_ready0", 32'(in_ready), 32'(1));
    check_eq("drain_y1", 32'(y), 32'h2);
    cycle();
    check_eq("drain_out_valid", 32'(out_valid), 32'(0));
    check_eq("drain_in_ready1", 32'(in_ready), 32'(1));
    drive(1'b0, '0, 1'b0); cycle();

    // Streaming 0x1..0x8 with out_ready held high; y checked by scoreboard.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'(i), 1'b1); cycle();
      check_eq("stream_count_one", 32'(out_valid && in_ready), 32'(1));
    end
    drive(1'b0, '0, 1'b1); cycle();
    check_eq("stream_empty", 32'(out_valid), 32'(0));
    check_eq("stream_sb_empty", 32'(exp_q.size()), 32'(0));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    repeat (3) cycle();
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
